axi_hs_fifo: RTL

//  Parametrised AXI4-style valid/ready buffer between one upstream source and one downstream sink.

---
 rtl/axi_hs_pkg.sv | 17 +
 rtl/axi_hs_ptr.sv | 27 ++
 rtl/axi_hs_fifo.sv | 117 +++++++++++
 3 files changed

// File: rtl/axi_hs_pkg.sv
// Shared helpers for the valid/ready buffer: width arithmetic and depth validation.
package axi_hs_pkg;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< r) < value) r = r + 1;
    end
    return r;
  endfunction

  function automatic bit is_pow2_f(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/axi_hs_ptr.sv
// Wrapping ring-buffer pointer: clears on clr, advances on inc, wraps naturally at 2**PTR_W.
module axi_hs_ptr #(
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_r;

  // Pointer register; clear wins over advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= {PTR_W{1'b0}};
    end else if (clr) begin
      ptr_r <= {PTR_W{1'b0}};
    end else if (inc) begin
      ptr_r <= ptr_r + PTR_W'(1);
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/axi_hs_fifo.sv
// Valid/ready ring buffer of DEPTH words with registered handshake outputs and a registered head word.
module axi_hs_fifo
  import axi_hs_pkg::*;
#(
  parameter int  DATA_W = 32,
  parameter int  DEPTH  = 4,
  localparam int CNT_W  = clog2_f(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              flush,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W         = clog2_f(DEPTH);
  localparam bit DEPTH_IS_POW2 = is_pow2_f(DEPTH);

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  if (!DEPTH_IS_POW2) begin : g_bad_depth
    $error("axi_hs_fifo: DEPTH must be a power of two >= 2");
  end

  entry_t           mem_r [DEPTH];
  entry_t           head_r;
  entry_t           head_nxt_s;
  logic [PTR_W-1:0] wr_ptr_s;
  logic [PTR_W-1:0] rd_ptr_s;
  logic [PTR_W-1:0] rd_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             s_ready_r;
  logic             m_valid_r;
  logic             push_s;
  logic             pop_s;

  assign push_s = s_valid & s_ready_r;
  assign pop_s  = m_valid_r & m_ready;

  axi_hs_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (push_s),
    .ptr   (wr_ptr_s)
  );

  axi_hs_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (pop_s),
    .ptr   (rd_ptr_s)
  );

  // Next occupancy and next head word; an empty-after-pop buffer forwards the incoming word
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
    rd_nxt_s = pop_s ? (rd_ptr_s + PTR_W'(1)) : rd_ptr_s;
    if (push_s && (wr_ptr_s == rd_nxt_s)) begin
      head_nxt_s = '{last: s_last, data: s_data};
    end else begin
      head_nxt_s = mem_r[rd_nxt_s];
    end
  end

  // Storage array; writes are suppressed while flushing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (push_s && !flush) begin
      mem_r[wr_ptr_s] <= '{last: s_last, data: s_data};
    end
  end

  // Occupancy, handshake flags and head word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r   <= '0;
      s_ready_r <= 1'b1;
      m_valid_r <= 1'b0;
      head_r    <= '0;
    end else if (flush) begin
      count_r   <= '0;
      s_ready_r <= 1'b1;
      m_valid_r <= 1'b0;
    end else begin
      count_r   <= count_nxt_s;
      s_ready_r <= (count_nxt_s != CNT_W'(DEPTH));
      m_valid_r <= (count_nxt_s != CNT_W'(0));
      head_r    <= head_nxt_s;
    end
  end

  assign s_ready = s_ready_r;
  assign m_valid = m_valid_r;
  assign m_data  = head_r.data;
  assign m_last  = head_r.last;
  assign count   = count_r;

endmodule
